// File: rtl/instruction_loader.sv
// Instruction image loader.
// Packs an incoming byte stream little-endian into OP_SIZE-bit words and
// writes them to consecutive BRAM addresses starting at 0. It then reads the
// whole image back through the same port and compares a read-back checksum
// against the write checksum. The BRAM port is only driven while busy; the
// CPU read path must wait for done_out.
module instruction_loader #(
  parameter int ADDRS   = 256,
  parameter int OP_SIZE = 8,
  localparam int ADDR_SIZE    = $clog2(ADDRS),
  localparam int BYTES_PER_OP = OP_SIZE / 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 start_in,
  input  logic [ADDR_SIZE:0]   length_in,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid_in,
  output logic                 byte_ready_out,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 error_out,
  output logic [OP_SIZE-1:0]   checksum_out,
  output logic [ADDR_SIZE-1:0] bram_addr,
  output logic                 bram_we,
  output logic                 bram_regce,
  output logic [OP_SIZE-1:0]   bram_din,
  input  logic [OP_SIZE-1:0]   bram_dout
);

  // Byte index width; at least one bit so single-byte words still work.
  localparam int BIDX_W = (BYTES_PER_OP > 1) ? $clog2(BYTES_PER_OP) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_VERIFY = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam logic [ADDR_SIZE:0] CNT_ONE   = (ADDR_SIZE + 1)'(1);
  localparam logic [ADDR_SIZE:0] CNT_MAX   = (ADDR_SIZE + 1)'(ADDRS);
  localparam logic [BIDX_W-1:0]  BIDX_ONE  = BIDX_W'(1);
  localparam logic [BIDX_W-1:0]  BIDX_LAST = BIDX_W'(BYTES_PER_OP - 1);

  // Control state
  logic [2:0]           state_q, state_d;
  logic [ADDR_SIZE:0]   len_q, len_d;       // words requested
  logic [BIDX_W-1:0]    bidx_q, bidx_d;     // byte position inside current word
  logic [OP_SIZE-1:0]   word_q, word_d;     // word being packed
  logic [ADDR_SIZE:0]   waddr_q, waddr_d;   // words written so far / next write address
  logic [ADDR_SIZE:0]   vcnt_q, vcnt_d;     // cycles spent in VERIFY
  logic [1:0]           vld_q, vld_d;       // read-data-returning tracker (2-cycle latency)
  logic [OP_SIZE-1:0]   wsum_q, wsum_d;     // write checksum
  logic [OP_SIZE-1:0]   rsum_q, rsum_d;     // read-back checksum
  logic                 err_q, err_d;

  // Registered outputs
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 we_q, we_d;
  logic [ADDR_SIZE-1:0] addr_q, addr_d;
  logic [OP_SIZE-1:0]   din_q, din_d;

  logic [OP_SIZE-1:0]   packed_s;           // word_q with the incoming byte merged in

  // Merge the incoming byte into its little-endian lane of the current word.
  always_comb begin
    packed_s = word_q;
    for (int k = 0; k < BYTES_PER_OP; k++) begin
      packed_s[8*k +: 8] = (bidx_q == BIDX_W'(k)) ? byte_in : word_q[8*k +: 8];
    end
  end

  // Next-state logic for the load / write / verify sequence.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bidx_d  = bidx_q;
    word_d  = word_q;
    waddr_d = waddr_q;
    vcnt_d  = vcnt_q;
    vld_d   = vld_q;
    wsum_d  = wsum_q;
    rsum_d  = rsum_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          len_d   = length_in;
          err_d   = 1'b0;
          wsum_d  = '0;
          rsum_d  = '0;
          bidx_d  = '0;
          word_d  = '0;
          waddr_d = '0;
          vcnt_d  = '0;
          vld_d   = 2'b00;
          if ((length_in == '0) || (length_in > CNT_MAX)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (byte_valid_in && ready_q) begin
          word_d = packed_s;
          if (bidx_q == BIDX_LAST) begin
            bidx_d  = '0;
            state_d = S_WRITE;
          end else begin
            bidx_d  = bidx_q + BIDX_ONE;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_WRITE: begin
        wsum_d  = wsum_q + word_q;
        waddr_d = waddr_q + CNT_ONE;
        if (waddr_d == len_q) begin
          vcnt_d  = '0;
          vld_d   = 2'b00;
          state_d = S_VERIFY;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_VERIFY: begin
        vcnt_d = vcnt_q + CNT_ONE;
        vld_d  = {vld_q[0], (vcnt_q < len_q)};
        if (vld_q[1]) begin
          rsum_d = rsum_q + bram_dout;
        end else begin
          rsum_d = rsum_q;
        end
        // The last word returns two cycles after its address, i.e. at len+1.
        if (vld_q[1] && (vcnt_q == (len_q + CNT_ONE))) begin
          err_d   = err_q | (rsum_d != wsum_q);
          state_d = S_DONE;
        end else begin
          state_d = S_VERIFY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state.
  always_comb begin
    ready_d = (state_d == S_LOAD);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    we_d    = (state_d == S_WRITE);
    case (state_d)
      S_WRITE: begin
        addr_d = waddr_q[ADDR_SIZE-1:0];
        din_d  = word_d;
      end
      S_VERIFY: begin
        addr_d = (vcnt_d < len_q) ? vcnt_d[ADDR_SIZE-1:0] : '0;
        din_d  = '0;
      end
      default: begin
        addr_d = '0;
        din_d  = '0;
      end
    endcase
  end

  // State and output registers; reset drops the BRAM port immediately.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      bidx_q  <= '0;
      word_q  <= '0;
      waddr_q <= '0;
      vcnt_q  <= '0;
      vld_q   <= 2'b00;
      wsum_q  <= '0;
      rsum_q  <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bidx_q  <= bidx_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
      vcnt_q  <= vcnt_d;
      vld_q   <= vld_d;
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
    end
  end

  assign byte_ready_out = ready_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;
  assign error_out      = err_q;
  assign checksum_out   = wsum_q;
  assign bram_addr      = addr_q;
  assign bram_we        = we_q;
  assign bram_regce     = 1'b1;
  assign bram_din       = din_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: an 8-bit and a 16-bit instance share one
// stimulus driver; each has its own 2-cycle-latency BRAM model that can
// corrupt one address on readback.
module tb_instruction_loader;

  localparam int ADDRS = 256;
  localparam int LIMIT = 3000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_n, start_s, sel, valid;
  logic [8:0] length;
  logic [7:0] byte_d;

  logic       cor_en;
  logic [7:0] cor_addr;
  logic [15:0] cor_val;

  logic        ready8, busy8, done8, err8, we8, regce8;
  logic [7:0]  sum8, addr8, din8, dout8;
  logic        ready16, busy16, done16, err16, we16, regce16;
  logic [15:0] sum16, din16, dout16;
  logic [7:0]  addr16;

  instruction_loader #(.ADDRS(ADDRS), .OP_SIZE(8)) dut8 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_s && !sel), .length_in(length),
    .byte_in(byte_d), .byte_valid_in(valid && !sel), .byte_ready_out(ready8),
    .busy_out(busy8), .done_out(done8), .error_out(err8), .checksum_out(sum8),
    .bram_addr(addr8), .bram_we(we8), .bram_regce(regce8), .bram_din(din8),
    .bram_dout(dout8));

  instruction_loader #(.ADDRS(ADDRS), .OP_SIZE(16)) dut16 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start_s && sel), .length_in(length),
    .byte_in(byte_d), .byte_valid_in(valid && sel), .byte_ready_out(ready16),
    .busy_out(busy16), .done_out(done16), .error_out(err16), .checksum_out(sum16),
    .bram_addr(addr16), .bram_we(we16), .bram_regce(regce16), .bram_din(din16),
    .bram_dout(dout16));

  // BRAM models: registered read then output register, 2-cycle latency.
  logic [7:0]  mem8 [0:255];
  logic [15:0] mem16 [0:255];
  logic [7:0]  r8a, r8b;
  logic [15:0] r16a, r16b;
  always @(posedge clk) begin
    if (we8) mem8[addr8] <= din8;
    r8a <= (cor_en && addr8 == cor_addr) ? cor_val[7:0] : mem8[addr8];
    r8b <= r8a;
    if (we16) mem16[addr16] <= din16;
    r16a <= (cor_en && addr16 == cor_addr) ? cor_val : mem16[addr16];
    r16b <= r16a;
  end
  assign dout8  = r8b;
  assign dout16 = r16b;

  // Outputs of the instance currently selected.
  logic        m_ready, m_busy, m_done, m_err, m_we, m_regce;
  logic [15:0] m_sum, m_din;
  logic [7:0]  m_addr;
  always_comb begin
    m_ready = sel ? ready16 : ready8;
    m_busy  = sel ? busy16  : busy8;
    m_done  = sel ? done16  : done8;
    m_err   = sel ? err16   : err8;
    m_we    = sel ? we16    : we8;
    m_regce = sel ? regce16 : regce8;
    m_sum   = sel ? sum16   : {8'h00, sum8};
    m_din   = sel ? din16   : {8'h00, din8};
    m_addr  = sel ? addr16  : addr8;
  end

  typedef struct { int cyc; logic [7:0] addr; logic [15:0] din; logic rdy; } wr_t;
  wr_t         wq[$];
  wr_t         mon_e;
  int          done_count = 0;
  int          done_cyc = 0;
  logic [15:0] done_sum;
  logic        done_err;

  // Monitor: log every write and the outputs seen on each done pulse.
  always @(posedge clk) begin
    #1;
    if (m_we) begin
      mon_e.cyc = cyc; mon_e.addr = m_addr; mon_e.din = m_din; mon_e.rdy = m_ready;
      wq.push_back(mon_e);
    end
    if (m_done) begin
      done_count = done_count + 1;
      done_cyc   = cyc;
      done_sum   = m_sum;
      done_err   = m_err;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  logic [7:0] stim[$];

  // One complete load: model the expected image, drive start and the byte
  // stream with random gaps, then check writes, timing and results.
  task automatic run_load(input int len, input bit s, input int gap, input bit poke,
                          input bit use_exp, input logic [15:0] exp_sum_t, input bit exp_err_t);
    int          bpo  = s ? 2 : 1;
    bit          good = (len >= 1) && (len <= ADDRS);
    logic [15:0] mask = s ? 16'hFFFF : 16'h00FF;
    logic [15:0] words[$];
    logic [15:0] wsum = 16'h0000;
    logic [15:0] rsum = 16'h0000;
    logic [15:0] e_sum;
    bit          e_err;
    int          t, base;
    int          bi = 0;
    int          k = 0;
    bit          poked = 1'b0;
    if (good) begin
      for (int i = 0; i < len; i++) begin
        logic [15:0] w;
        w = 16'h0000;
        for (int b = 0; b < bpo; b++) w = w | (16'(stim[i*bpo+b]) << (8*b));
        words.push_back(w);
        wsum = (wsum + w) & mask;
        rsum = (rsum + ((cor_en && int'(cor_addr) == i) ? (cor_val & mask) : w)) & mask;
      end
    end
    e_sum = good ? wsum : 16'h0000;
    e_err = good ? (rsum != wsum) : 1'b1;
    if (use_exp) begin
      e_sum = exp_sum_t;
      e_err = exp_err_t;
    end

    @(negedge clk);
    sel = s; start_s = 1'b1; length = 9'(len); t = cyc; base = done_count; wq.delete();
    @(negedge clk);
    start_s = 1'b0; length = 9'($urandom_range(0, 511));
    check("busy_after_start", m_busy, 1);
    if (good) check("ready_after_start", m_ready, 1);
    else      check("bad_len_done_now", m_done, 1);

    while (done_count == base && k < LIMIT) begin
      if (good && bi < stim.size() && $urandom_range(0, gap) == 0) begin
        valid = 1'b1; byte_d = stim[bi];
        if (m_ready) bi++;
      end else begin
        valid = 1'b0; byte_d = 8'($urandom);
      end
      if (poke && !poked && good && wq.size() == len && cyc >= wq[len-1].cyc + 2) begin
        start_s = 1'b1; length = 9'd0; poked = 1'b1;
      end else begin
        start_s = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    valid = 1'b0; start_s = 1'b0;

    check("done_within_budget", (k < LIMIT), 1);
    if (good) begin
      check("write_count", wq.size(), len);
      for (int i = 0; i < wq.size() && i < len; i++) begin
        check($sformatf("write_addr[%0d]", i), wq[i].addr, i);
        check($sformatf("write_din[%0d]", i), wq[i].din, words[i]);
        check($sformatf("ready_in_write[%0d]", i), wq[i].rdy, 0);
      end
      if (wq.size() > 0) check("done_after_last_write", done_cyc - wq[wq.size()-1].cyc, len + 3);
    end else begin
      check("no_write_bad_len", wq.size(), 0);
      check("bad_len_done_cycle", done_cyc - t, 1);
    end
    check("checksum", done_sum, e_sum);
    check("error", done_err, e_err);
    @(negedge clk);
    check("idle_after_done", m_busy, 0);
    check("done_one_cycle", m_done, 0);
    repeat (3) @(negedge clk);
    check("single_done", done_count - base, 1);
  endtask

  typedef struct {
    int len; bit s; int nb; logic [31:0] bytes;
    bit cen; logic [7:0] ca; logic [15:0] cv;
    logic [15:0] es; bit ee; int gap; bit poke;
  } vec_t;
  vec_t tbl [7];

  initial begin
    tbl[0] = '{3,   1'b0, 3, 32'h00332211, 1'b0, 8'd0, 16'h0000, 16'h0066, 1'b0, 0, 1'b0};
    tbl[1] = '{2,   1'b1, 4, 32'h56781234, 1'b0, 8'd0, 16'h0000, 16'h68AC, 1'b0, 3, 1'b0};
    tbl[2] = '{2,   1'b0, 2, 32'h000002FF, 1'b1, 8'd1, 16'h0003, 16'h0001, 1'b1, 0, 1'b0};
    tbl[3] = '{0,   1'b0, 0, 32'h00000000, 1'b0, 8'd0, 16'h0000, 16'h0000, 1'b1, 0, 1'b0};
    tbl[4] = '{257, 1'b0, 0, 32'h00000000, 1'b0, 8'd0, 16'h0000, 16'h0000, 1'b1, 0, 1'b0};
    tbl[5] = '{3,   1'b0, 3, 32'h00030201, 1'b0, 8'd0, 16'h0000, 16'h0006, 1'b0, 1, 1'b1};
    tbl[6] = '{1,   1'b1, 2, 32'h0000BBAA, 1'b0, 8'd0, 16'h0000, 16'hBBAA, 1'b0, 2, 1'b0};

    rst_n = 1'b0; start_s = 1'b0; sel = 1'b0; valid = 1'b0; length = 9'd0; byte_d = 8'h00;
    cor_en = 1'b0; cor_addr = 8'd0; cor_val = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_busy", m_busy, 0);
    check("rst_ready", m_ready, 0);
    check("rst_done", m_done, 0);
    check("rst_error", m_err, 0);
    check("rst_we", m_we, 0);
    check("rst_addr", m_addr, 0);
    check("rst_din", m_din, 0);
    check("rst_checksum", m_sum, 0);
    check("rst_regce", m_regce, 1);
    check("rst_checksum16", sum16, 0);
    check("rst_busy16", busy16, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of directed loads.
    for (int v = 0; v < 7; v++) begin
      stim.delete();
      for (int b = 0; b < tbl[v].nb; b++) stim.push_back(tbl[v].bytes[8*b +: 8]);
      cor_en = tbl[v].cen; cor_addr = tbl[v].ca; cor_val = tbl[v].cv;
      run_load(tbl[v].len, tbl[v].s, tbl[v].gap, tbl[v].poke, 1'b1, tbl[v].es, tbl[v].ee);
    end
    cor_en = 1'b0;

    // Reset while LOAD waits for the second of two words.
    sel = 1'b0; wq.delete();
    @(negedge clk); start_s = 1'b1; length = 9'd2;
    @(negedge clk); start_s = 1'b0; valid = 1'b1; byte_d = 8'hA1;
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    check("rst_test_in_load", m_ready, 1);
    check("rst_test_one_write", wq.size(), 1);
    rst_n = 1'b0;
    #1;
    check("midload_rst_busy", m_busy, 0);
    check("midload_rst_we", m_we, 0);
    check("midload_rst_ready", m_ready, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    stim.delete(); stim.push_back(8'h5C);
    run_load(1, 1'b0, 0, 1'b0, 1'b1, 16'h005C, 1'b0);

    // Reset during a write cycle drops bram_we at once.
    @(negedge clk); start_s = 1'b1; length = 9'd2;
    @(negedge clk); start_s = 1'b0; valid = 1'b1; byte_d = 8'hC3;
    @(negedge clk); valid = 1'b0;
    check("write_cycle_we", m_we, 1);
    rst_n = 1'b0;
    #1;
    check("write_rst_we", m_we, 0);
    check("write_rst_busy", m_busy, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Randomized loads against the reference model.
    for (int r = 0; r < 10; r++) begin
      bit s;
      int len;
      s   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 12);
      stim.delete();
      for (int b = 0; b < len * (s ? 2 : 1); b++) stim.push_back(8'($urandom));
      cor_en   = 1'($urandom_range(0, 1));
      cor_addr = 8'($urandom_range(0, len - 1));
      cor_val  = 16'($urandom);
      run_load(len, s, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, 16'h0000, 1'b0);
    end

    // Full-size image, clean and with the last address corrupted.
    for (int r = 0; r < 2; r++) begin
      stim.delete();
      for (int b = 0; b < ADDRS; b++) stim.push_back(8'($urandom));
      cor_en = 1'(r); cor_addr = 8'd255; cor_val = 16'(stim[255] + 8'd1);
      run_load(ADDRS, 1'b0, 0, 1'b0, 1'b0, 16'h0000, 1'b0);
    end
    cor_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
